// File: rtl/rvga_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : rvga_dmem_responder
// Brief    : Single-outstanding load/store responder backed by a 128-bit
//            cacheline array, with RISC-V style load extension and store merge.
// Revision : 1.0 - initial release
// ============================================================================
module rvga_dmem_responder #(
    parameter int LINES_P = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_v_i,
    output logic        req_ready_o,
    input  logic        req_w_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        resp_v_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o
);
    localparam int LINE_W = $clog2(LINES_P);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOOKUP = 2'd1;
    localparam logic [1:0] c_ST_WRITE  = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [1:0]        state_q, state_d;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [1:0]        byte_q;
    logic [1:0]        word_q;
    logic [LINE_W-1:0] line_idx_q;
    logic [31:0]       st_data_q;
    logic [127:0]      line_q;
    logic [31:0]       resp_data_q;
    logic              resp_err_q;
    logic [127:0]      mem_q [LINES_P];

    logic              w_accept;
    logic              w_req_err;
    logic              w_mem_we;
    logic [127:0]      w_rd_line;
    logic [31:0]       w_rd_word;
    logic [7:0]        w_rd_byte;
    logic [15:0]       w_rd_half;
    logic [31:0]       w_ld_data;
    logic [31:0]       w_old_word;
    logic [31:0]       w_st_mask;
    logic [31:0]       w_st_lanes;
    logic [127:0]      w_wr_line;
    logic              w_unused_addr;

    // Address bits above the line index alias onto the same lines.
    assign w_unused_addr = ^req_addr_i[31:4+LINE_W];

    assign w_accept    = req_v_i && (state_q == c_ST_IDLE);
    assign req_ready_o = (state_q == c_ST_IDLE);
    assign resp_v_o    = (state_q == c_ST_RESP);
    assign resp_data_o = resp_data_q;
    assign resp_err_o  = resp_err_q;

    always_comb begin
        w_req_err = 1'b0;
        if (req_w_i) begin
            case (req_funct3_i)
                c_F3_B:  w_req_err = 1'b0;
                c_F3_H:  w_req_err = req_addr_i[0];
                c_F3_W:  w_req_err = |req_addr_i[1:0];
                default: w_req_err = 1'b1;
            endcase
        end else begin
            case (req_funct3_i)
                c_F3_B, c_F3_BU: w_req_err = 1'b0;
                c_F3_H, c_F3_HU: w_req_err = req_addr_i[0];
                c_F3_W:          w_req_err = |req_addr_i[1:0];
                default:         w_req_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE:   if (req_v_i) state_d = w_req_err ? c_ST_RESP : c_ST_LOOKUP;
            c_ST_LOOKUP: state_d = is_store_q ? c_ST_WRITE : c_ST_RESP;
            c_ST_WRITE:  state_d = c_ST_RESP;
            c_ST_RESP:   if (resp_ready_i) state_d = c_ST_IDLE;
            default:     state_d = c_ST_IDLE;
        endcase
    end

    assign w_rd_line = mem_q[line_idx_q];

    always_comb begin
        w_rd_word = w_rd_line[{word_q, 5'd0} +: 32];
        w_rd_byte = w_rd_word[{byte_q, 3'd0} +: 8];
        w_rd_half = w_rd_word[{byte_q[1], 4'd0} +: 16];
        case (funct3_q)
            c_F3_B:  w_ld_data = {{24{w_rd_byte[7]}}, w_rd_byte};
            c_F3_BU: w_ld_data = {24'd0, w_rd_byte};
            c_F3_H:  w_ld_data = {{16{w_rd_half[15]}}, w_rd_half};
            c_F3_HU: w_ld_data = {16'd0, w_rd_half};
            default: w_ld_data = w_rd_word;
        endcase
    end

    // Store data is replicated across lanes; the mask picks the target lane.
    always_comb begin
        w_old_word = line_q[{word_q, 5'd0} +: 32];
        case (funct3_q)
            c_F3_B: begin
                w_st_mask  = 32'h0000_00FF << {byte_q, 3'd0};
                w_st_lanes = {4{st_data_q[7:0]}};
            end
            c_F3_H: begin
                w_st_mask  = 32'h0000_FFFF << {byte_q[1], 4'd0};
                w_st_lanes = {2{st_data_q[15:0]}};
            end
            default: begin
                w_st_mask  = 32'hFFFF_FFFF;
                w_st_lanes = st_data_q;
            end
        endcase
        w_wr_line = line_q;
        w_wr_line[{word_q, 5'd0} +: 32] = (w_old_word & ~w_st_mask) | (w_st_lanes & w_st_mask);
    end

    assign w_mem_we = (state_q == c_ST_WRITE) && !reset_i;

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            mem_q[line_idx_q] <= w_wr_line;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            is_store_q <= req_w_i;
            funct3_q   <= req_funct3_i;
            byte_q     <= req_addr_i[1:0];
            word_q     <= req_addr_i[3:2];
            line_idx_q <= req_addr_i[4 +: LINE_W];
            st_data_q  <= req_data_i;
        end
        if (state_q == c_ST_LOOKUP) begin
            line_q <= w_rd_line;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= c_ST_IDLE;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                c_ST_IDLE: begin
                    if (req_v_i && w_req_err) begin
                        resp_data_q <= 32'd0;
                        resp_err_q  <= 1'b1;
                    end
                end
                c_ST_LOOKUP: begin
                    resp_data_q <= is_store_q ? 32'd0 : w_ld_data;
                    resp_err_q  <= 1'b0;
                end
                c_ST_WRITE: begin
                    resp_data_q <= 32'd0;
                    resp_err_q  <= 1'b0;
                end
                default: begin
                    if (resp_ready_i) begin
                        resp_data_q <= 32'd0;
                        resp_err_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvga_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvga_dmem_responder
// Brief    : Directed self-checking bench for rvga_dmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvga_dmem_responder;
    localparam logic [2:0] c_LB  = 3'b000;
    localparam logic [2:0] c_LH  = 3'b001;
    localparam logic [2:0] c_LW  = 3'b010;
    localparam logic [2:0] c_LBU = 3'b100;
    localparam logic [2:0] c_LHU = 3'b101;
    localparam logic [2:0] c_SB  = 3'b000;
    localparam logic [2:0] c_SH  = 3'b001;
    localparam logic [2:0] c_SW  = 3'b010;

    logic        r_clk = 1'b0;
    logic        r_reset = 1'b1;
    logic        r_req_v = 1'b0;
    logic        r_req_w = 1'b0;
    logic [2:0]  r_req_funct3 = 3'd0;
    logic [31:0] r_req_addr = 32'd0;
    logic [31:0] r_req_data = 32'd0;
    logic        r_resp_ready = 1'b1;
    logic        w_req_ready;
    logic        w_resp_v;
    logic [31:0] w_resp_data;
    logic        w_resp_err;

    int n_checks = 0;
    int n_pass   = 0;

    rvga_dmem_responder #(.LINES_P(256)) u_dut (
        .clk_i        (r_clk),
        .reset_i      (r_reset),
        .req_v_i      (r_req_v),
        .req_ready_o  (w_req_ready),
        .req_w_i      (r_req_w),
        .req_funct3_i (r_req_funct3),
        .req_addr_i   (r_req_addr),
        .req_data_i   (r_req_data),
        .resp_v_o     (w_resp_v),
        .resp_ready_i (r_resp_ready),
        .resp_data_o  (w_resp_data),
        .resp_err_o   (w_resp_err)
    );

    always #5 r_clk = ~r_clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Issues one request, then scrambles the inputs to prove capture at accept.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] rdata,
                          output logic rerr, output int lat);
        @(negedge r_clk);
        r_req_v = 1'b1; r_req_w = w; r_req_funct3 = f3;
        r_req_addr = addr; r_req_data = data; r_resp_ready = 1'b1;
        @(posedge r_clk); #1;
        r_req_v = 1'b0; r_req_w = ~w; r_req_funct3 = ~f3;
        r_req_addr = ~addr; r_req_data = ~data;
        lat = 0;
        while (lat <= 10) begin
            @(negedge r_clk);
            lat++;
            if (w_resp_v) break;
        end
        rdata = w_resp_data;
        rerr  = w_resp_err;
        @(posedge r_clk); #1;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
        logic [31:0] d; logic e; int lat;
        do_req(1'b0, f3, addr, 32'h0, d, e, lat);
        check_value({tag, "_data"}, d, exp);
        check_value({tag, "_err"}, {31'd0, e}, 32'd0);
        check_value({tag, "_lat"}, lat, 32'd2);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data);
        logic [31:0] d; logic e; int lat;
        do_req(1'b1, f3, addr, data, d, e, lat);
        check_value({tag, "_data"}, d, 32'd0);
        check_value({tag, "_err"}, {31'd0, e}, 32'd0);
        check_value({tag, "_lat"}, lat, 32'd3);
    endtask

    task automatic do_bad(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] addr);
        logic [31:0] d; logic e; int lat;
        do_req(w, f3, addr, 32'hFFFF_FFFF, d, e, lat);
        check_value({tag, "_data"}, d, 32'd0);
        check_value({tag, "_err"}, {31'd0, e}, 32'd1);
        check_value({tag, "_lat"}, lat, 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check_value({tag, "_ready"}, {31'd0, w_req_ready}, 32'd1);
        check_value({tag, "_respv"}, {31'd0, w_resp_v}, 32'd0);
        check_value({tag, "_data"}, w_resp_data, 32'd0);
        check_value({tag, "_err"}, {31'd0, w_resp_err}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge r_clk);
        check_idle("reset");
        r_reset = 1'b0;

        do_store("sw14", c_SW, 32'h14, 32'h1111_1111);
        do_store("sw18", c_SW, 32'h18, 32'h2222_2222);
        do_store("sw1c", c_SW, 32'h1C, 32'h3333_3333);
        do_store("sw10", c_SW, 32'h10, 32'hDEAD_BEEF);
        do_load("lw10", c_LW, 32'h10, 32'hDEAD_BEEF);
        do_load("lb13", c_LB, 32'h13, 32'hFFFF_FFDE);
        do_load("lbu13", c_LBU, 32'h13, 32'h0000_00DE);
        do_load("lh12", c_LH, 32'h12, 32'hFFFF_DEAD);
        do_load("lhu10", c_LHU, 32'h10, 32'h0000_BEEF);

        do_store("sb11", c_SB, 32'h11, 32'hAAAA_AA55);
        do_load("lw10_sb", c_LW, 32'h10, 32'hDEAD_55EF);
        do_load("lw14_keep", c_LW, 32'h14, 32'h1111_1111);
        do_load("lw18_keep", c_LW, 32'h18, 32'h2222_2222);
        do_load("lw1c_keep", c_LW, 32'h1C, 32'h3333_3333);

        do_store("sw10_again", c_SW, 32'h10, 32'hDEAD_BEEF);
        do_bad("err_lw12", 1'b0, c_LW, 32'h12);
        do_bad("err_sh13", 1'b1, c_SH, 32'h13);
        do_bad("err_ld011", 1'b0, 3'b011, 32'h10);
        do_bad("err_lh11", 1'b0, c_LH, 32'h11);
        do_bad("err_sw11", 1'b1, c_SW, 32'h11);
        do_bad("err_st011", 1'b1, 3'b011, 32'h10);
        do_load("lw10_after_err", c_LW, 32'h10, 32'hDEAD_BEEF);

        do_store("sh12", c_SH, 32'h12, 32'h5555_CAFE);
        do_load("lw10_sh", c_LW, 32'h10, 32'hCAFE_BEEF);
        do_load("lh12_sh", c_LH, 32'h12, 32'hFFFF_CAFE);
        do_load("lb10", c_LB, 32'h10, 32'hFFFF_FFEF);
        do_load("lbu11", c_LBU, 32'h11, 32'h0000_00BE);

        // Response back-pressure: held outputs, and a store offered meanwhile is refused.
        begin
            int lat;
            @(negedge r_clk);
            r_req_v = 1'b1; r_req_w = 1'b0; r_req_funct3 = c_LW;
            r_req_addr = 32'h10; r_resp_ready = 1'b0;
            @(posedge r_clk); #1;
            r_req_w = 1'b1; r_req_funct3 = c_SW; r_req_data = 32'h0;
            lat = 0;
            while (lat <= 10) begin
                @(negedge r_clk);
                lat++;
                if (w_resp_v) break;
            end
            check_value("hold_lat", lat, 32'd2);
            for (int i = 0; i < 5; i++) begin
                check_value("hold_respv", {31'd0, w_resp_v}, 32'd1);
                check_value("hold_data", w_resp_data, 32'hCAFE_BEEF);
                check_value("hold_err", {31'd0, w_resp_err}, 32'd0);
                check_value("hold_ready", {31'd0, w_req_ready}, 32'd0);
                @(negedge r_clk);
            end
            r_req_v = 1'b0; r_resp_ready = 1'b1;
            @(negedge r_clk);
            check_idle("hold_release");
        end
        do_load("lw10_after_hold", c_LW, 32'h10, 32'hCAFE_BEEF);

        do_store("sw1010", c_SW, 32'h1010, 32'h0000_1234);
        do_load("lw10_alias", c_LW, 32'h10, 32'h0000_1234);

        // Reset during the WRITE cycle must leave the line untouched.
        do_store("sw20", c_SW, 32'h20, 32'h0BAD_F00D);
        @(negedge r_clk);
        r_req_v = 1'b1; r_req_w = 1'b1; r_req_funct3 = c_SW;
        r_req_addr = 32'h20; r_req_data = 32'hFFFF_FFFF;
        @(posedge r_clk); #1;
        r_req_v = 1'b0;
        @(negedge r_clk);
        @(negedge r_clk);
        r_reset = 1'b1;
        @(negedge r_clk);
        check_idle("rst_in_write");
        r_reset = 1'b0;
        do_load("lw20_after_rst", c_LW, 32'h20, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
